// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Serial pattern detector with runtime pattern, per-bit care
//                mask, selectable overlap and a saturating match counter.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detector_param #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                           flux,
    input  logic                           reset,
    input  logic                           in,
    input  logic                           in_valid,
    input  logic                           cfg_load,
    input  logic [PAT_LEN-1:0]             pattern,
    input  logic [PAT_LEN-1:0]             care_mask,
    input  logic                           overlap,
    input  logic                           clear,
    output logic                           out,
    output logic [$clog2(PAT_LEN+1)-1:0]   progress,
    output logic [CNT_W-1:0]               match_count,
    output logic                           ovf
);

    localparam int                    c_fill_w = $clog2(PAT_LEN + 1);
    localparam logic [c_fill_w-1:0]   c_full   = c_fill_w'(PAT_LEN);

    logic [PAT_LEN-1:0]  r_win;
    logic [PAT_LEN-1:0]  r_pat;
    logic [PAT_LEN-1:0]  r_mask;
    logic                r_overlap;
    logic [c_fill_w-1:0] r_fill;
    logic                r_out;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;

    logic [PAT_LEN-1:0]  w_next_win;
    logic [c_fill_w-1:0] w_next_fill;
    logic                w_match;
    logic                w_count_sat;

    // A one-bit window has no older bits to shift, so it is simply replaced.
    generate
        if (PAT_LEN == 1) begin : g_win_single
            assign w_next_win = in;
        end else begin : g_win_shift
            assign w_next_win = {r_win[PAT_LEN-2:0], in};
        end
    endgenerate

    assign w_next_fill = (r_fill == c_full) ? r_fill : r_fill + c_fill_w'(1);
    assign w_match     = (w_next_fill == c_full) &&
                         (((w_next_win ^ r_pat) & r_mask) == '0);
    assign w_count_sat = &r_count;

    // Every use of 'in' below is qualified by in_valid, keeping X out of state.
    always_ff @(posedge flux or negedge reset) begin
        if (!reset) begin
            r_win     <= '0;
            r_pat     <= '0;
            r_mask    <= '1;
            r_overlap <= 1'b0;
            r_fill    <= '0;
            r_out     <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else if (cfg_load) begin
            r_pat     <= pattern;
            r_mask    <= care_mask;
            r_overlap <= overlap;
            r_win     <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
        end else begin
            r_out <= 1'b0;
            if (clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            if (in_valid) begin
                if (w_match) begin
                    r_out <= 1'b1;
                    if (r_overlap) begin
                        r_win  <= w_next_win;
                        r_fill <= w_next_fill;
                    end else begin
                        r_win  <= '0;
                        r_fill <= '0;
                    end
                    // A clear in the same cycle restarts the count from zero.
                    if (clear) begin
                        r_count <= CNT_W'(1);
                    end else if (w_count_sat) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end else begin
                    r_win  <= w_next_win;
                    r_fill <= w_next_fill;
                end
            end
        end
    end

    assign out         = r_out;
    assign progress    = r_fill;
    assign match_count = r_count;
    assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Scoreboard bench for seq_detector_param (4-bit and 1-bit
//                instances).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

    logic       flux;
    // 4-bit pattern instance
    logic       rst_a, in_a, vld_a, cfg_a, ov_a, clr_a;
    logic [3:0] pat_a, mask_a;
    logic       out_a, ovf_a;
    logic [2:0] prog_a;
    logic [7:0] cnt_a;
    // 1-bit pattern instance with a 2-bit counter
    logic       rst_b, in_b, vld_b, cfg_b, ov_b, clr_b;
    logic [0:0] pat_b, mask_b;
    logic       out_b, ovf_b;
    logic [0:0] prog_b;
    logic [1:0] cnt_b;

    int total = 0;
    int bad   = 0;
    int qa[$];
    int qb[$];

    seq_detector_param #(.PAT_LEN(4), .CNT_W(8)) u_dut_a (
        .flux(flux), .reset(rst_a), .in(in_a), .in_valid(vld_a),
        .cfg_load(cfg_a), .pattern(pat_a), .care_mask(mask_a),
        .overlap(ov_a), .clear(clr_a), .out(out_a), .progress(prog_a),
        .match_count(cnt_a), .ovf(ovf_a)
    );

    seq_detector_param #(.PAT_LEN(1), .CNT_W(2)) u_dut_b (
        .flux(flux), .reset(rst_b), .in(in_b), .in_valid(vld_b),
        .cfg_load(cfg_b), .pattern(pat_b), .care_mask(mask_b),
        .overlap(ov_b), .clear(clr_b), .out(out_b), .progress(prog_b),
        .match_count(cnt_b), .ovf(ovf_b)
    );

    initial flux = 1'b0;
    always #5 flux = ~flux;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitors: every out pulse must match the oldest queued expectation.
    always @(negedge flux) begin
        if (out_a !== 1'b0) begin
            if (qa.size() == 0) chk("a_unexpected_pulse", {31'd0, out_a}, 32'd0);
            else chk("a_pulse_count", {24'd0, cnt_a}, qa.pop_front());
        end
        if (out_b !== 1'b0) begin
            if (qb.size() == 0) chk("b_unexpected_pulse", {31'd0, out_b}, 32'd0);
            else chk("b_pulse_count", {30'd0, cnt_b}, qb.pop_front());
        end
    end

    task automatic step_a(input logic v, input logic b, input logic clr, input logic m, input int c);
        @(negedge flux);
        cfg_a = 1'b0; vld_a = v; in_a = b; clr_a = clr;
        #1 if (m) qa.push_back(c);
        @(posedge flux);
    endtask

    task automatic load_a(input logic [3:0] p, input logic [3:0] mk, input logic o, input logic v, input logic b);
        @(negedge flux);
        cfg_a = 1'b1; pat_a = p; mask_a = mk; ov_a = o; vld_a = v; in_a = b; clr_a = 1'b0;
        @(posedge flux);
    endtask

    task automatic idle_a;
        @(negedge flux);
        cfg_a = 1'b0; vld_a = 1'b0; in_a = 1'bx; clr_a = 1'b0;
        #2;
    endtask

    task automatic step_b(input logic v, input logic b, input logic clr, input logic m, input int c);
        @(negedge flux);
        cfg_b = 1'b0; vld_b = v; in_b = b; clr_b = clr;
        #1 if (m) qb.push_back(c);
        @(posedge flux);
    endtask

    task automatic idle_b;
        @(negedge flux);
        cfg_b = 1'b0; vld_b = 1'b0; in_b = 1'bx; clr_b = 1'b0;
        #2;
    endtask

    initial begin
        rst_a = 1'b0; in_a = 1'b0; vld_a = 1'b0; cfg_a = 1'b0; ov_a = 1'b0;
        clr_a = 1'b0; pat_a = '0; mask_a = '0;
        rst_b = 1'b0; in_b = 1'b0; vld_b = 1'b0; cfg_b = 1'b0; ov_b = 1'b0;
        clr_b = 1'b0; pat_b = '0; mask_b = '0;
        repeat (3) @(posedge flux);
        #2;
        chk("rst_out", {31'd0, out_a}, 32'd0);
        chk("rst_progress", {29'd0, prog_a}, 32'd0);
        chk("rst_count", {24'd0, cnt_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        @(negedge flux);
        rst_a = 1'b1; rst_b = 1'b1;

        // First accepted bit under reset config (pattern 0000, full mask).
        step_a(1, 1, 0, 0, 0);
        idle_a;
        chk("first_bit_progress", {29'd0, prog_a}, 32'd1);

        // Non-overlap 1011
        load_a(4'b1011, 4'b1111, 1'b0, 1'b0, 1'b0);
        idle_a;
        chk("load_progress", {29'd0, prog_a}, 32'd0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 0, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 1, 0, 1, 1);
        step_a(1, 0, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        idle_a;
        chk("novl_count", {24'd0, cnt_a}, 32'd1);
        chk("novl_progress", {29'd0, prog_a}, 32'd3);
        chk("novl_queue_empty", qa.size(), 32'd0);

        // Overlap 1011, count cleared first
        load_a(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
        step_a(0, 1'bx, 1, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 0, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 1, 0, 1, 1);
        step_a(1, 0, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 1, 0, 1, 2);
        idle_a;
        chk("ovl_count", {24'd0, cnt_a}, 32'd2);
        chk("ovl_progress", {29'd0, prog_a}, 32'd4);
        chk("ovl_queue_empty", qa.size(), 32'd0);

        // Don't-care bit 2 lets 1101 match 1001; gaps carry X
        load_a(4'b1001, 4'b1011, 1'b0, 1'b0, 1'b0);
        step_a(0, 1'bx, 1, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(0, 1'bx, 0, 0, 0);
        step_a(0, 1'bx, 0, 0, 0);
        idle_a;
        chk("gap_progress", {29'd0, prog_a}, 32'd2);
        step_a(1, 0, 0, 0, 0);
        step_a(1, 1, 0, 1, 1);
        idle_a;
        chk("dc_count", {24'd0, cnt_a}, 32'd1);
        chk("dc_progress", {29'd0, prog_a}, 32'd0);
        chk("dc_queue_empty", qa.size(), 32'd0);

        // cfg_load mid-pattern discards the bit presented with it
        load_a(4'b1011, 4'b1111, 1'b0, 1'b0, 1'b0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 0, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        idle_a;
        chk("pre_load_progress", {29'd0, prog_a}, 32'd3);
        load_a(4'b1011, 4'b1111, 1'b0, 1'b1, 1'b1);
        idle_a;
        chk("midload_progress", {29'd0, prog_a}, 32'd0);
        step_a(1, 0, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        step_a(1, 1, 0, 0, 0);
        idle_a;
        chk("discard_progress", {29'd0, prog_a}, 32'd3);
        chk("discard_queue_empty", qa.size(), 32'd0);

        // Async reset between edges
        @(posedge flux);
        #2 rst_a = 1'b0;
        #1;
        chk("async_progress", {29'd0, prog_a}, 32'd0);
        chk("async_count", {24'd0, cnt_a}, 32'd0);
        chk("async_out", {31'd0, out_a}, 32'd0);
        @(negedge flux);
        rst_a = 1'b1;
        step_a(1, 1, 0, 0, 0);
        idle_a;
        chk("resume_progress", {29'd0, prog_a}, 32'd1);

        // Saturation on the 1-bit, 2-bit-counter instance
        @(negedge flux);
        cfg_b = 1'b1; pat_b = 1'b1; mask_b = 1'b1; ov_b = 1'b1; vld_b = 1'b0;
        @(posedge flux);
        step_b(1, 1, 0, 1, 1);
        step_b(1, 1, 0, 1, 2);
        step_b(1, 1, 0, 1, 3);
        step_b(1, 1, 0, 1, 3);
        step_b(1, 1, 0, 1, 3);
        idle_b;
        chk("sat_count", {30'd0, cnt_b}, 32'd3);
        chk("sat_ovf", {31'd0, ovf_b}, 32'd1);
        chk("sat_progress", {31'd0, prog_b}, 32'd1);
        step_b(1, 1, 1, 1, 1);
        idle_b;
        chk("clr_count", {30'd0, cnt_b}, 32'd1);
        chk("clr_ovf", {31'd0, ovf_b}, 32'd0);
        chk("b_queue_empty", qb.size(), 32'd0);

        repeat (2) @(posedge flux);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
